serial_bill_subtractor: RTL and testbench

- Parametrised, digit-serial successor to the fixed 13-bit ripple subtractor in the bill-amount datapath.
- Computes A - B over WIDTH bits, DIGIT bits per clock, and carries the borrow between cycles in a register.
- Adds a valid/ready handshake, a borrow-out (underflow) flag, a zero flag, and an optional saturate-at-zero mode, so that a bill balance never wraps negative.
- Sits between the tariff/amount calculator and the bill output register.

---
 rtl/serial_bill_subtractor_pkg.sv | 10 +
 rtl/serial_bill_subtractor_if.sv | 27 ++
 rtl/serial_bill_subtractor_digit_sub.sv | 21 ++
 rtl/serial_bill_subtractor.sv | 100 ++++++++++
 tb/tb_serial_bill_subtractor.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_bill_subtractor_pkg.sv
// Shared types and helpers for the digit-serial bill-amount subtractor.
package bill_pkg;
  localparam int BILL_WIDTH = 13;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int ncyc(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction
endpackage

// File: rtl/serial_bill_subtractor_if.sv
// Operand/result handshake bundle between the amount calculator and the subtractor.
interface serial_bill_subtractor_if
  import bill_pkg::*;
#(
  parameter int WIDTH = BILL_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sat_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output in_valid, a, b, sat_mode, out_ready,
    input  in_ready, out_valid, diff, borrow, zero
  );

  modport slave (
    input  in_valid, a, b, sat_mode, out_ready,
    output in_ready, out_valid, diff, borrow, zero
  );
endinterface

// File: rtl/serial_bill_subtractor_digit_sub.sv
// Combinational DIGIT-bit subtractor built as a ripple of full-subtractor cells.
module digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    assign d[i]       = x[i] ^ y[i] ^ brw[i];
    assign brw[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign bout = brw[DIGIT];
endmodule

// File: rtl/serial_bill_subtractor.sv
// Digit-serial A - B with borrow register, valid/ready handshake and optional clamp at zero.
module serial_bill_subtractor
  import bill_pkg::*;
#(
  parameter int WIDTH = BILL_WIDTH,
  parameter int DIGIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_bill_subtractor_if.slave  bus
);
  localparam int NCYC = ncyc(WIDTH, DIGIT);
  localparam int PW   = NCYC * DIGIT;
  localparam int IDXW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCYC - 1);

  state_t           state;
  logic [PW-1:0]    a_r;
  logic [PW-1:0]    b_r;
  logic             sat_r;
  logic             brw;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] res;
  logic [DIGIT-1:0] x_s;
  logic [DIGIT-1:0] y_s;
  logic [DIGIT-1:0] d_s;
  logic             bout_s;

  always_comb begin
    x_s = a_r[idx*DIGIT +: DIGIT];
    y_s = b_r[idx*DIGIT +: DIGIT];
  end

  digit_sub #(.DIGIT(DIGIT)) u_digit (
    .x    (x_s),
    .y    (y_s),
    .bin  (brw),
    .d    (d_s),
    .bout (bout_s)
  );

  // Operands are zero-padded above WIDTH, so the top slice's borrow-out equals
  // the borrow out of bit WIDTH-1 and padding result bits are simply dropped.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < WIDTH; j++) begin
      if (j / DIGIT == int'(idx)) acc_nxt[j] = d_s[j % DIGIT];
    end
    res = (sat_r && bout_s) ? '0 : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.diff      <= '0;
      bus.borrow    <= 1'b0;
      bus.zero      <= 1'b0;
      idx           <= '0;
      brw           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r          <= PW'(bus.a);
            b_r          <= PW'(bus.b);
            sat_r        <= bus.sat_mode;
            brw          <= 1'b0;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          brw <= bout_s;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.diff      <= res;
            bus.borrow    <= bout_s;
            bus.zero      <= (res == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bill_subtractor.sv
// Scoreboard bench for serial_bill_subtractor: directed scenarios plus parameter sweeps.
`timescale 1ns/1ps
module tb_serial_bill_subtractor;
  import bill_pkg::*;

  localparam int W  = BILL_WIDTH;
  localparam int D  = 4;
  localparam int NC = 4;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sweep_go = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_bill_subtractor_if #(.WIDTH(W)) bif();
  serial_bill_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sat);
    exp_t e;
    logic [32:0] full;
    logic [31:0] mask;
    mask     = (32'd1 << w) - 32'd1;
    full     = {1'b0, av} - {1'b0, bv};
    e.borrow = (av < bv);
    e.diff   = (sat && e.borrow) ? 32'd0 : (full[31:0] & mask);
    e.zero   = (e.diff == 32'd0);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sat);
    int n = 0;
    bif.a        = av;
    bif.b        = bv;
    bif.sat_mode = sat;
    bif.in_valid = 1'b1;
    while (!bif.in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!bif.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout in_ready=%0b required=1", bif.in_ready);
    end else begin
      sb.push_back(model(W, 32'(av), 32'(bv), sat));
    end
    cyc();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic rdy_seen);
    lat      = 0;
    rdy_seen = 1'b0;
    while (!bif.out_valid && lat < 40) begin
      if (bif.in_ready) rdy_seen = 1'b1;
      cyc();
      lat++;
    end
    if (!bif.out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout out_valid=0 required=1 after %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    vectors++;
    if ({bif.in_ready, bif.out_valid, bif.diff, bif.borrow, bif.zero} !== {1'b1, 1'b0, 13'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values rdy=%0b ov=%0b diff=%0d brw=%0b zero=%0b required 1 0 0 0 0",
               bif.in_ready, bif.out_valid, bif.diff, bif.borrow, bif.zero);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if ({bif.in_ready, bif.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset_idle rdy=%0b ov=%0b required rdy=1 ov=0", bif.in_ready, bif.out_valid);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    logic rdy;
    send(13'd1500, 13'd275, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    vectors++;
    if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
      miscompares++;
      $display("FAIL basic_result diff=%0d brw=%0b zero=%0b required %0d %0b %0b",
               bif.diff, bif.borrow, bif.zero, e.diff[W-1:0], e.borrow, e.zero);
    end
    vectors++;
    if (lat !== NC) begin
      miscompares++;
      $display("FAIL basic_latency got=%0d required=%0d", lat, NC);
    end
    vectors++;
    if (rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_in_ready_busy got=%0b required=0", rdy);
    end
    cyc();
    vectors++;
    if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_done_one_cycle ov=%0b rdy=%0b required ov=0 rdy=1", bif.out_valid, bif.in_ready);
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    int   lat;
    logic rdy;
    for (int s = 0; s < 2; s++) begin
      send(13'd275, 13'd1500, s[0]);
      wait_out(lat, rdy);
      e = sb.pop_front();
      vectors++;
      if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
        miscompares++;
        $display("FAIL underflow_sat%0d diff=%0d brw=%0b zero=%0b required %0d %0b %0b",
                 s, bif.diff, bif.borrow, bif.zero, e.diff[W-1:0], e.borrow, e.zero);
      end
      cyc();
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    int   lat;
    logic rdy;
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    av[0] = 13'd8191; bv[0] = 13'd8191;
    av[1] = 13'd0;    bv[1] = 13'd1;
    for (int k = 0; k < 2; k++) begin
      send(av[k], bv[k], 1'b0);
      wait_out(lat, rdy);
      e = sb.pop_front();
      vectors++;
      if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
        miscompares++;
        $display("FAIL extremes_%0d diff=%0d brw=%0b zero=%0b required %0d %0b %0b",
                 k, bif.diff, bif.borrow, bif.zero, e.diff[W-1:0], e.borrow, e.zero);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic rdy;
    bif.out_ready = 1'b0;
    send(13'd500, 13'd200, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    vectors++;
    if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
      miscompares++;
      $display("FAIL stall_result diff=%0d required=%0d", bif.diff, e.diff[W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = (i % 2 == 0);
      bif.a        = W'($urandom());
      bif.b        = W'($urandom());
      bif.sat_mode = 1'b1;
      cyc();
      vectors++;
      if ({bif.out_valid, bif.in_ready, bif.diff} !== {1'b1, 1'b0, e.diff[W-1:0]}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d ov=%0b rdy=%0b diff=%0d required 1 0 %0d",
                 i, bif.out_valid, bif.in_ready, bif.diff, e.diff[W-1:0]);
      end
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    cyc();
    vectors++;
    if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release ov=%0b rdy=%0b required ov=0 rdy=1", bif.out_valid, bif.in_ready);
    end
    send(13'd100, 13'd99, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    vectors++;
    if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
      miscompares++;
      $display("FAIL back_to_back diff=%0d brw=%0b required %0d %0b", bif.diff, bif.borrow, e.diff[W-1:0], e.borrow);
    end
    cyc();
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat;
    logic rdy;
    logic pulse;
    send(13'd1500, 13'd275, 1'b0);
    e = sb.pop_front();
    cyc();
    rst = 1'b1;
    cyc();
    vectors++;
    if ({bif.out_valid, bif.in_ready, bif.diff, bif.borrow, bif.zero} !== {1'b0, 1'b1, 13'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_reset ov=%0b rdy=%0b diff=%0d brw=%0b zero=%0b required 0 1 0 0 0",
               bif.out_valid, bif.in_ready, bif.diff, bif.borrow, bif.zero);
    end
    rst   = 1'b0;
    pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bif.out_valid) pulse = 1'b1;
    end
    vectors++;
    if (pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_pulse out_valid_seen=%0b required=0", pulse);
    end
    send(13'd40, 13'd15, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    vectors++;
    if ({bif.diff, bif.borrow, bif.zero} !== {e.diff[W-1:0], e.borrow, e.zero}) begin
      miscompares++;
      $display("FAIL after_abort diff=%0d required=%0d", bif.diff, e.diff[W-1:0]);
    end
    cyc();
  endtask

  localparam int SW [3] = '{13, 13, 16};
  localparam int SD [3] = '{1, 13, 5};

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int GW = SW[g];
    localparam int GD = SD[g];
    localparam int GN = (GW + GD - 1) / GD;
    logic done_flag = 1'b0;

    serial_bill_subtractor_if #(.WIDTH(GW)) sif();
    serial_bill_subtractor #(.WIDTH(GW), .DIGIT(GD)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
    );

    initial begin
      exp_t q[$];
      exp_t e;
      logic [GW-1:0] ra;
      logic [GW-1:0] rb;
      logic rs;
      int lat;
      sif.in_valid  = 1'b0;
      sif.a         = '0;
      sif.b         = '0;
      sif.sat_mode  = 1'b0;
      sif.out_ready = 1'b1;
      wait (sweep_go);
      cyc();
      for (int i = 0; i < 1000; i++) begin
        ra = GW'($urandom());
        rb = (i % 8 == 0) ? ra : GW'($urandom());
        if (i == 1) begin ra = '0; rb = '1; end
        if (i == 2) begin ra = '1; rb = '0; end
        rs = (i % 3 == 0);
        sif.a = ra; sif.b = rb; sif.sat_mode = rs; sif.in_valid = 1'b1;
        lat = 0;
        while (!sif.in_ready && lat < 50) begin cyc(); lat++; end
        q.push_back(model(GW, 32'(ra), 32'(rb), rs));
        cyc();
        sif.in_valid = 1'b0;
        lat = 0;
        while (!sif.out_valid && lat < 40) begin cyc(); lat++; end
        e = q.pop_front();
        vectors++;
        if ({sif.diff, sif.borrow, sif.zero} !== {e.diff[GW-1:0], e.borrow, e.zero}) begin
          miscompares++;
          $display("FAIL sweep_w%0d_d%0d a=%0d b=%0d sat=%0b diff=%0d brw=%0b zero=%0b required %0d %0b %0b",
                   GW, GD, ra, rb, rs, sif.diff, sif.borrow, sif.zero, e.diff[GW-1:0], e.borrow, e.zero);
        end
        vectors++;
        if (lat !== GN) begin
          miscompares++;
          $display("FAIL sweep_latency_w%0d_d%0d got=%0d required=%0d", GW, GD, lat, GN);
        end
        cyc();
      end
      done_flag = 1'b1;
    end
  end

  task automatic test_param_sweep();
    int n = 0;
    sweep_go = 1'b1;
    while (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag) && n < 60000) begin
      cyc();
      n++;
    end
    vectors++;
    if (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag)) begin
      miscompares++;
      $display("FAIL sweep_timeout done=%0b%0b%0b required=111",
               g_sweep[2].done_flag, g_sweep[1].done_flag, g_sweep[0].done_flag);
    end
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.sat_mode  = 1'b0;
    bif.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_underflow();
    test_extremes();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
